// File: rtl/comparator_sched_pkg.sv
// Shared types and constants for the round-robin comparator scheduler.
package comparator_sched_pkg;

    localparam int unsigned CMP_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

    // ID tag width; at least one bit so a tag port always exists.
    function automatic int unsigned calc_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comparator_32_bit.sv
// Unsigned 32-bit magnitude comparator: exactly one of eq/gt/lt is set.
module comparator_32_bit
    import comparator_sched_pkg::*;
(
    input  logic [CMP_WIDTH-1:0] a_i,
    input  logic [CMP_WIDTH-1:0] b_i,
    output logic                 eq_o,
    output logic                 gt_o,
    output logic                 lt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i >  b_i);
    assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr_i.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_c_o
);

    int unsigned     idx;
    logic [ID_W-1:0] sel;
    logic            found;

    always_comb begin
        grant_c_o = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = ID_W'(idx);
            if (!found && req_i[sel]) begin
                grant_c_o[sel] = 1'b1;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/comparator_rr_scheduler.sv
// Shares one 32-bit comparator among NUM_REQ requesters via round-robin
// arbitration; results come back tagged with the requester ID.
module comparator_rr_scheduler
    import comparator_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = CMP_WIDTH,
    parameter int unsigned ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_eq,
    output logic                     rsp_gt,
    output logic                     rsp_lt,
    output logic                     busy
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic              eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_id;
    logic [WIDTH-1:0]   win_a, win_b;
    logic               cmp_eq, cmp_gt, cmp_lt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .grant_c_o (grant)
    );

    comparator_32_bit u_cmp (
        .a_i  (op_a_q),
        .b_i  (op_b_q),
        .eq_o (cmp_eq),
        .gt_o (cmp_gt),
        .lt_o (cmp_lt)
    );

    // Encode the one-hot grant and select the winner's operands.
    always_comb begin
        win_id = '0;
        win_a  = '0;
        win_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_id = ID_W'(i);
                win_a  = req_a[i*WIDTH +: WIDTH];
                win_b  = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                // Grant is withheld while reset is asserted.
                req_ready = rst_n ? grant : '0;
                if (|grant) begin
                    op_a_d   = win_a;
                    op_b_d   = win_b;
                    id_d     = win_id;
                    rr_ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
                    state_d  = CMP;
                end
            end
            CMP: begin
                eq_d    = cmp_eq;
                gt_d    = cmp_gt;
                lt_d    = cmp_lt;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_eq    = eq_q;
    assign rsp_gt    = gt_q;
    assign rsp_lt    = lt_q;

endmodule

// File: tb/tb_comparator_rr_scheduler.sv
// Testbench for comparator_rr_scheduler: vector table, reference model with
// response scoreboard, and directed multi-cycle sequences.
module tb_comparator_rr_scheduler;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_ready = 1'b1;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic           rsp_eq, rsp_gt, rsp_lt;
    logic           busy;

    comparator_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_eq    (rsp_eq),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model and scoreboard
    typedef enum int {M_IDLE, M_CMP, M_RESP} mstate_t;
    typedef struct { int id; logic eq; logic gt; logic lt; } exp_t;

    mstate_t      m_state = M_IDLE;
    int           m_ptr = 0;
    exp_t         sb_q[$];
    int           order[$];
    int           hs_id_log[$];
    logic [2:0]   hs_res_log[$];
    int           grant_cnt = 0, hs_cnt = 0;
    int           last_grant_cyc = 0, last_grant_id = -1, last_hs_cyc = 0;
    int           last_id = -1;
    logic [2:0]   last_res = '0;
    logic         prev_rv = 1'b0;
    int           mon_w;
    logic [N-1:0] mon_rdy;
    logic [W-1:0] mon_a, mon_b;

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_state = M_IDLE;
            m_ptr   = 0;
            sb_q.delete();
            prev_rv = 1'b0;
        end else begin
            mon_w   = (m_state == M_IDLE) ? rr_pick(req_valid, m_ptr) : -1;
            mon_rdy = '0;
            if (mon_w >= 0) mon_rdy[mon_w] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(mon_rdy));
            check("rsp_valid", 64'(rsp_valid), 64'(m_state == M_RESP));
            check("busy", 64'(busy), 64'(m_state != M_IDLE));
            if (m_state == M_RESP) begin
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", 64'(sb_q.size()), 64'd1);
                end else begin
                    check("rsp_id", 64'(rsp_id), 64'(sb_q[0].id));
                    check("rsp_result", 64'({rsp_eq, rsp_gt, rsp_lt}),
                          64'({sb_q[0].eq, sb_q[0].gt, sb_q[0].lt}));
                end
                if (!prev_rv) check("latency", 64'(cyc - last_grant_cyc), 64'd2);
            end
            prev_rv = rsp_valid;
            case (m_state)
                M_IDLE: if (mon_w >= 0) begin
                    mon_a = req_a[mon_w*W +: W];
                    mon_b = req_b[mon_w*W +: W];
                    sb_q.push_back('{id: mon_w, eq: (mon_a == mon_b), gt: (mon_a > mon_b), lt: (mon_a < mon_b)});
                    m_ptr          = (mon_w + 1) % N;
                    m_state        = M_CMP;
                    grant_cnt++;
                    last_grant_cyc = cyc;
                    last_grant_id  = mon_w;
                    order.push_back(mon_w);
                end
                M_CMP: m_state = M_RESP;
                default: if (rsp_ready) begin
                    last_id  = int'(rsp_id);
                    last_res = {rsp_eq, rsp_gt, rsp_lt};
                    hs_id_log.push_back(last_id);
                    hs_res_log.push_back(last_res);
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    hs_cnt++;
                    last_hs_cyc = cyc;
                    m_state     = M_IDLE;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int start, input string name);
        for (int k = 0; k < 30 && grant_cnt == start; k++) tick();
        check(name, 64'(grant_cnt != start), 64'd1);
    endtask

    task automatic wait_hs(input int target, input string name);
        for (int k = 0; k < 40 && hs_cnt < target; k++) tick();
        check(name, 64'(hs_cnt >= target), 64'd1);
    endtask

    task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
    endtask

    // Single request from an idle scheduler: granted in the cycle it is presented.
    task automatic do_single(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        int g0, h0, dc;
        g0 = grant_cnt;
        h0 = hs_cnt;
        set_ops(id, a, b);
        req_valid[id] = 1'b1;
        dc = cyc;
        wait_grant(g0, "single_grant_seen");
        req_valid[id] = 1'b0;
        check("single_grant_id", 64'(last_grant_id), 64'(id));
        check("single_grant_same_cycle", 64'(last_grant_cyc), 64'(dc));
        wait_hs(h0 + 1, "single_handshake_seen");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        check({tag, "_rsp_result"}, 64'({rsp_eq, rsp_gt, rsp_lt}), 64'd0);
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  res;   // {eq, gt, lt}
    } vec_t;

    vec_t tv[7];
    int   exp_order[5];

    initial begin
        int g0, h0, x_cyc;

        tv[0] = '{id: 2, a: 32'h8000_0000, b: 32'h0000_0008, res: 3'b010};
        tv[1] = '{id: 1, a: 32'h8000_0008, b: 32'h8000_8000, res: 3'b001};
        tv[2] = '{id: 0, a: 32'hF209_0808, b: 32'hF209_0808, res: 3'b100};
        tv[3] = '{id: 3, a: 32'h0000_0000, b: 32'hFFFF_FFFF, res: 3'b001};
        tv[4] = '{id: 3, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFE, res: 3'b010};
        tv[5] = '{id: 0, a: 32'h0000_0000, b: 32'h0000_0000, res: 3'b100};
        tv[6] = '{id: 1, a: 32'h7FFF_FFFF, b: 32'h8000_0000, res: 3'b001};
        exp_order = '{0, 1, 2, 3, 0};

        // Reset with every requester valid: nothing may be granted.
        req_valid = '1;
        repeat (3) tick();
        check_outputs_zero("reset");
        req_valid = '0;
        rst_n = 1'b1;

        // Vector table, single requester each
        for (int i = 0; i < 7; i++) begin
            do_single(tv[i].id, tv[i].a, tv[i].b);
            check("tv_rsp_id", 64'(last_id), 64'(tv[i].id));
            check("tv_rsp_result", 64'(last_res), 64'(tv[i].res));
        end

        // Asynchronous reset in the middle of RESP
        rsp_ready = 1'b0;
        g0 = grant_cnt;
        set_ops(3, 32'h1234, 32'h1235);
        req_valid[3] = 1'b1;
        wait_grant(g0, "rstmid_grant_seen");
        req_valid[3] = 1'b0;
        for (int k = 0; k < 10 && !rsp_valid; k++) tick();
        check("rstmid_in_resp", 64'(rsp_valid), 64'd1);
        set_ops(0, 32'h5, 32'h5);
        req_valid[0] = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("rstmid");
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // Contention: all four valid, pointer restarts at 0
        order.delete();
        hs_id_log.delete();
        hs_res_log.delete();
        g0 = grant_cnt;
        h0 = hs_cnt;
        set_ops(0, 32'h5, 32'h3);
        set_ops(1, 32'h8000_0008, 32'h8000_8000);
        set_ops(2, 32'h7, 32'h7);
        set_ops(3, 32'h0, 32'h1);
        req_valid = '1;
        for (int k = 0; k < 40 && grant_cnt < g0 + 5; k++) tick();
        req_valid = '0;
        wait_hs(h0 + 5, "contention_handshakes");
        for (int k = 0; k < 5; k++) begin
            check("contention_order", 64'((order.size() > k) ? order[k] : -1), 64'(exp_order[k]));
        end
        check("contention_req1_id", 64'((hs_id_log.size() > 1) ? hs_id_log[1] : -1), 64'd1);
        check("contention_req1_lt", 64'((hs_res_log.size() > 1) ? hs_res_log[1] : 3'b000), 64'(3'b001));

        // Wrap and skip: pointer 3 after granting 2, then only requester 1
        do_single(2, 32'h10, 32'h20);
        do_single(1, 32'h30, 32'h20);
        check("skip_rsp_result", 64'(last_res), 64'(3'b010));
        g0 = grant_cnt;
        h0 = hs_cnt;
        set_ops(1, 32'h1, 32'h1);
        set_ops(2, 32'h2, 32'h1);
        req_valid[1] = 1'b1;
        req_valid[2] = 1'b1;
        wait_grant(g0, "ptr2_grant_seen");
        req_valid[2] = 1'b0;
        check("ptr2_winner", 64'(last_grant_id), 64'd2);
        wait_grant(g0 + 1, "ptr2_loser_grant_seen");
        req_valid[1] = 1'b0;
        check("ptr2_loser_next", 64'(last_grant_id), 64'd1);
        wait_hs(h0 + 2, "ptr2_handshakes");

        // Backpressure: five cycles held, handshake in the sixth, new grant next
        rsp_ready = 1'b0;
        g0 = grant_cnt;
        h0 = hs_cnt;
        set_ops(2, 32'hAAAA_0000, 32'h0000_BBBB);
        req_valid[2] = 1'b1;
        wait_grant(g0, "bp_grant_seen");
        req_valid[2] = 1'b0;
        for (int k = 0; k < 10 && !rsp_valid; k++) tick();
        x_cyc = cyc;
        set_ops(0, 32'h9, 32'hA);
        req_valid[0] = 1'b1;
        repeat (5) tick();
        check("bp_no_handshake", 64'(hs_cnt), 64'(h0));
        rsp_ready = 1'b1;
        wait_grant(g0 + 1, "bp_next_grant_seen");
        req_valid[0] = 1'b0;
        check("bp_handshake_cycle", 64'(last_hs_cyc - x_cyc), 64'd5);
        check("bp_next_grant_id", 64'(last_grant_id), 64'd0);
        check("bp_next_grant_gap", 64'(last_grant_cyc - last_hs_cyc), 64'd1);
        wait_hs(h0 + 2, "bp_final_handshake");
        check("bp_final_lt", 64'(last_res), 64'(3'b001));

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
